moa_tree_pipe: RTL

- Parametrised, pipelined multi-operand adder: sums N_OPS unsigned WIDTH-bit operands per transaction through a balanced binary tree of two-input adders.
- One register stage per tree level, so a new operand set can be accepted every cycle.
- Full-precision result: no carry is dropped, unlike the earlier 8x8-bit combinational tree.
- Valid/ready handshake on both sides with a global pipeline stall; sits between operand producers and result consumers in the multi-operand adder datapath.

---
 rtl/moa_tree_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/moa_tree_pipe.sv
// moa_tree_pipe: pipelined multi-operand adder.
//   Sums N_OPS unsigned WIDTH-bit operands through a balanced binary tree of
//   two-input adders. There is one register stage per tree level, so the block
//   accepts one operand set per cycle. The result keeps full precision.
//   A single advance enable stalls the whole pipeline when the consumer holds
//   off.
//
// Optional build macro: MOA_SATURATE_EN
//   When defined, out_sum narrows to WIDTH bits and saturates to 2^WIDTH-1.
//   When saturation happens, out_ovf is raised.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  operand-set handshake (in_ready = advance enable)
//   in_ops          N_OPS packed operands, operand k at [k*WIDTH +: WIDTH]
//   out_valid/ready result handshake
//   out_sum         sum (SW bits, or WIDTH bits when saturating)
//   out_ovf         saturation flag (MOA_SATURATE_EN only)

// One adder node of the tree: registered, loads only when the pipe advances.
module moa_add_node #(
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  output logic [IW:0]   s
);
  always_ff @(posedge clk)
    if (en) s <= {1'b0, a} + {1'b0, b};
endmodule

module moa_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int N_OPS  = 8,
  parameter int LEVELS = $clog2(N_OPS),
  parameter int SW     = WIDTH + LEVELS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] in_ops,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef MOA_SATURATE_EN
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_ovf
`else
  output logic [SW-1:0]          out_sum
`endif
);

  logic            adv;
  logic [LEVELS:1] vld_pipe;
  logic [SW-1:0]   root;

  assign out_valid = vld_pipe[LEVELS];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // Valid shift register. While adv is high, in_ready is high too,
  // so in_valid alone qualifies entry into level 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= LEVELS; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Level l holds N_OPS>>l sums of WIDTH+l bits. Each level widens by one
  // bit, so no carry is ever lost.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int IW = WIDTH + l - 1;
    localparam int NN = N_OPS >> l;
    logic [IW-1:0] src [2*NN];
    logic [IW:0]   s   [NN];

    if (l == 1) begin : g_src_in
      for (genvar k = 0; k < 2*NN; k++) begin : g_k
        assign src[k] = in_ops[k*WIDTH +: WIDTH];
      end
    end else begin : g_src_lvl
      for (genvar k = 0; k < 2*NN; k++) begin : g_k
        assign src[k] = g_lvl[l-1].s[k];
      end
    end

    for (genvar k = 0; k < NN; k++) begin : g_node
      moa_add_node #(.IW(IW)) u_node (
        .clk (clk),
        .en  (adv),
        .a   (src[2*k]),
        .b   (src[2*k+1]),
        .s   (s[k])
      );
    end
  end

  assign root = g_lvl[LEVELS].s[0];

  // Bubbles still clock junk through the adders. The output is therefore
  // masked by out_valid, which also gives out_sum=0 after reset.
`ifdef MOA_SATURATE_EN
  logic sat;
  assign sat     = |root[SW-1:WIDTH];
  assign out_sum = !out_valid ? '0 : (sat ? {WIDTH{1'b1}} : root[WIDTH-1:0]);
  assign out_ovf = out_valid & sat;
`else
  assign out_sum = out_valid ? root : '0;
`endif

endmodule
